// File: rtl/icache_ctrl_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache controller.
// Address split: offset [3:0], index [8:4], tag [31:9]; word select [3:2].
package icache_ctrl_pkg;
   localparam int ICACHE_NUM_LINES      = 32;
   localparam int ICACHE_LINE_SIZE      = 16;
   localparam int ICACHE_TAG_WIDTH      = 23;
   localparam int PERF_COUNTER_WIDTH    = 32;
   localparam int ICACHE_WORDS_PER_LINE = ICACHE_LINE_SIZE / 4;
   localparam int ICACHE_OFFSET_W       = $clog2(ICACHE_LINE_SIZE);
   localparam int ICACHE_INDEX_W        = $clog2(ICACHE_NUM_LINES);
   localparam int ICACHE_WORD_SEL_W     = $clog2(ICACHE_WORDS_PER_LINE);

   typedef enum logic [1:0] {IC_IDLE, IC_REQ, IC_WAIT, IC_FILL} icache_state_e;
endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache controller.
// master = the cache controller, slave = IF stage plus backing memory.
interface icache_ctrl_if;
   logic        cpu_req_valid;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_rdata;
   logic        cpu_rvalid;
   logic        cpu_stall;
   logic        flush;
   // Request channel: a word request transfers on the edge where mem_req_valid
   // and mem_req_ready are both 1; valid and addr hold steady until then.
   // Response channel has no ready: each mem_resp_valid cycle carries one word.
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   modport master (
      input  cpu_req_valid, cpu_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
      output cpu_rdata, cpu_rvalid, cpu_stall, mem_req_valid, mem_req_addr
   );
   modport slave (
      output cpu_req_valid, cpu_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
      input  cpu_rdata, cpu_rvalid, cpu_stall, mem_req_valid, mem_req_addr
   );
endinterface

// File: rtl/icache_ctrl_tag_store.sv
// Valid/tag/data arrays: combinational read, per-word data write, tag+valid write.
// Valid bits clear asynchronously on rst and synchronously on flush.
module icache_tag_store
   import icache_ctrl_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [ICACHE_INDEX_W-1:0]    rd_index,
   input  logic [ICACHE_WORD_SEL_W-1:0] rd_word,
   output logic                         rd_valid,
   output logic [ICACHE_TAG_WIDTH-1:0]  rd_tag,
   output logic [31:0]                  rd_data,
   input  logic                         word_we,
   input  logic [ICACHE_INDEX_W-1:0]    wr_index,
   input  logic [ICACHE_WORD_SEL_W-1:0] wr_word,
   input  logic [31:0]                  wr_data,
   input  logic                         tag_we,
   input  logic [ICACHE_TAG_WIDTH-1:0]  wr_tag,
   input  logic                         wr_valid
);
   logic [ICACHE_NUM_LINES-1:0] valid_q;
   logic [ICACHE_TAG_WIDTH-1:0] tag_q  [ICACHE_NUM_LINES];
   logic [31:0]                 data_q [ICACHE_NUM_LINES][ICACHE_WORDS_PER_LINE];

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_data  = data_q[rd_index][rd_word];

   // The per-line write follows the flush clear, so the line write takes priority
   // on its own bit; the caller already drives wr_valid low during a flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         if (flush)  valid_q           <= '0;
         if (tag_we) valid_q[wr_index] <= wr_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_we)  tag_q[wr_index]           <= wr_tag;
      if (word_we) data_q[wr_index][wr_word] <= wr_data;
   end
endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped I-cache controller: hit lookup, 4-word line refill, FENCE.I flush.
// Optional macro ICACHE_PERF_EN builds saturating hit/miss counters.
module icache_ctrl
   import icache_ctrl_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   icache_ctrl_if.master                 bus,
   output logic [PERF_COUNTER_WIDTH-1:0] perf_hits,
   output logic [PERF_COUNTER_WIDTH-1:0] perf_misses,
   output icache_state_e                 dbg_state
);
   localparam int LINE_W = 32 - ICACHE_OFFSET_W;

   icache_state_e               state_q;
   logic [1:0]                  cnt_q;
   logic [1:0]                  cnt_next;
   logic                        kill_q;
   logic [LINE_W-1:0]           line_q;
   logic                        mem_req_valid_q;
   logic [31:0]                 mem_req_addr_q;
   logic                        rd_valid;
   logic [ICACHE_TAG_WIDTH-1:0] rd_tag;
   logic [31:0]                 rd_data;
   logic                        lookup;
   logic                        hit;
   logic                        miss;
   logic                        unused_addr_bits;

   assign unused_addr_bits = ^bus.cpu_addr[1:0];
   assign cnt_next         = cnt_q + 2'd1;

   // Lookup only happens in IDLE and is suppressed while reset is held.
   assign lookup = bus.cpu_req_valid && (state_q == IC_IDLE) && !rst;
   assign hit    = lookup && rd_valid && (rd_tag == bus.cpu_addr[31 -: ICACHE_TAG_WIDTH]);
   assign miss   = lookup && !hit;

   assign bus.cpu_rvalid    = hit;
   assign bus.cpu_rdata     = hit ? rd_data : 32'd0;
   assign bus.cpu_stall     = (state_q != IC_IDLE) || miss;
   assign bus.mem_req_valid = mem_req_valid_q;
   assign bus.mem_req_addr  = mem_req_addr_q;
   assign dbg_state         = state_q;

   icache_tag_store u_store (
      .clk      (clk),
      .rst      (rst),
      .flush    (bus.flush),
      .rd_index (bus.cpu_addr[ICACHE_OFFSET_W +: ICACHE_INDEX_W]),
      .rd_word  (bus.cpu_addr[2 +: ICACHE_WORD_SEL_W]),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .word_we  ((state_q == IC_WAIT) && bus.mem_resp_valid),
      .wr_index (line_q[0 +: ICACHE_INDEX_W]),
      .wr_word  (cnt_q),
      .wr_data  (bus.mem_resp_data),
      .tag_we   (state_q == IC_FILL),
      .wr_tag   (line_q[LINE_W-1 -: ICACHE_TAG_WIDTH]),
      .wr_valid (!(kill_q || bus.flush))
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IC_IDLE;
         cnt_q           <= 2'd0;
         kill_q          <= 1'b0;
         line_q          <= '0;
         mem_req_valid_q <= 1'b0;
         mem_req_addr_q  <= 32'd0;
      end else begin
         // A refill in flight cannot be cancelled; remember to drop its valid bit.
         if (bus.flush && (state_q != IC_IDLE)) kill_q <= 1'b1;
         case (state_q)
            IC_IDLE: if (miss) begin
               line_q          <= bus.cpu_addr[31:ICACHE_OFFSET_W];
               cnt_q           <= 2'd0;
               mem_req_valid_q <= 1'b1;
               mem_req_addr_q  <= {bus.cpu_addr[31:ICACHE_OFFSET_W], {ICACHE_OFFSET_W{1'b0}}};
               state_q         <= IC_REQ;
            end
            IC_REQ: if (bus.mem_req_ready) begin
               mem_req_valid_q <= 1'b0;
               state_q         <= IC_WAIT;
            end
            IC_WAIT: if (bus.mem_resp_valid) begin
               cnt_q <= cnt_next;
               if (cnt_q == 2'd3) begin
                  state_q <= IC_FILL;
               end else begin
                  mem_req_valid_q <= 1'b1;
                  mem_req_addr_q  <= {line_q, cnt_next, 2'b00};
                  state_q         <= IC_REQ;
               end
            end
            IC_FILL: begin
               kill_q  <= 1'b0;
               state_q <= IC_IDLE;
            end
            default: state_q <= IC_IDLE;
         endcase
      end
   end

`ifdef ICACHE_PERF_EN
   logic [PERF_COUNTER_WIDTH-1:0] hits_q;
   logic [PERF_COUNTER_WIDTH-1:0] misses_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else begin
         if (hit && (hits_q != '1))    hits_q   <= hits_q + 1'b1;
         if (miss && (misses_q != '1)) misses_q <= misses_q + 1'b1;
      end
   end

   assign perf_hits   = hits_q;
   assign perf_misses = misses_q;
`else
   assign perf_hits   = '0;
   assign perf_misses = '0;
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: randomized fetches against a line-level cache model
// and a backing-memory responder with random ready and response latency.
module tb_icache_ctrl;
   import icache_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   icache_ctrl_if bus ();
   logic [PERF_COUNTER_WIDTH-1:0] perf_hits;
   logic [PERF_COUNTER_WIDTH-1:0] perf_misses;
   icache_state_e                 dbg_state;

   icache_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .perf_hits   (perf_hits),
      .perf_misses (perf_misses),
      .dbg_state   (dbg_state)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: which lines are resident and with what tag, plus event counts.
   logic [31:0] m_valid;
   logic [22:0] m_tag [32];
   int          m_hits;
   int          m_misses;
   logic [31:0] exp_q [$];
   logic [31:0] req_log [$];
   int          bp_left;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Backing memory: decides ready and responses on the falling edge.
   initial begin : mem_model
      logic        pend;
      int          lat_left;
      logic [31:0] pend_addr;
      pend = 1'b0; lat_left = 0; pend_addr = 32'd0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = 32'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend = 1'b0;
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
         end else begin
            bus.mem_resp_valid = 1'b0;
            if (pend) begin
               if (lat_left == 0) begin
                  bus.mem_resp_valid = 1'b1;
                  bus.mem_resp_data  = mem_word(pend_addr);
                  pend = 1'b0;
               end else begin
                  lat_left--;
               end
            end
            bus.mem_req_ready = 1'b0;
            if (bus.mem_req_valid && !pend) begin
               if (bp_left > 0) begin
                  bp_left--;
               end else if ($urandom_range(0, 3) != 0) begin
                  bus.mem_req_ready = 1'b1;
                  req_log.push_back(bus.mem_req_addr);
                  pend_addr = bus.mem_req_addr;
                  pend      = 1'b1;
                  lat_left  = $urandom_range(0, 2);
               end
            end
         end
      end
   end

   // One fetch as the IF stage sees it: hold the request until it hits.
   // flush_word >= 0 pulses flush while the refill waits on that word.
   task automatic do_fetch(input logic [31:0] addr, input int flush_word);
      logic [4:0]  idx;
      logic [22:0] tag;
      logic [31:0] base;
      logic        done;
      logic        flushed;
      int          cycles;
      idx  = addr[8:4];
      tag  = addr[31:9];
      base = {addr[31:4], 4'h0};
      @(posedge clk); #1;
      bus.cpu_req_valid = 1'b1;
      bus.cpu_addr      = addr;
      #1;
      if (m_valid[idx] && m_tag[idx] == tag) begin
         checks++; if (bus.cpu_rvalid !== 1'b1) begin errors++; $display("FAIL hit_rvalid @%h: got %b want 1", addr, bus.cpu_rvalid); end
         checks++; if (bus.cpu_rdata !== mem_word(addr)) begin errors++; $display("FAIL hit_rdata @%h: got %h want %h", addr, bus.cpu_rdata, mem_word(addr)); end
         checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL hit_stall @%h: got %b want 0", addr, bus.cpu_stall); end
         checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL hit_no_mem_req @%h: got %b want 0", addr, bus.mem_req_valid); end
         m_hits++;
      end else begin
         checks++; if (bus.cpu_stall !== 1'b1 || bus.cpu_rvalid !== 1'b0) begin
            errors++; $display("FAIL miss_detect @%h: stall=%b rvalid=%b want stall=1 rvalid=0", addr, bus.cpu_stall, bus.cpu_rvalid);
         end
         m_misses++;
         req_log.delete();
         exp_q.delete();
         for (int w = 0; w < 4; w++) exp_q.push_back(base + 32'(4 * w));
         done = 1'b0; flushed = 1'b0; cycles = 0;
         while (!done && cycles < 400) begin
            @(posedge clk); #1;
            bus.flush = 1'b0;
            #1;
            cycles++;
            if (bus.cpu_rvalid === 1'b1) begin
               done = 1'b1;
            end else begin
               checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL refill_stall @%h: got %b want 1", addr, bus.cpu_stall); end
               if (bus.mem_req_valid === 1'b1) begin
                  checks++;
                  if (req_log.size() >= exp_q.size()) begin
                     errors++; $display("FAIL extra_mem_req @%h: addr %h beyond %0d expected", addr, bus.mem_req_addr, exp_q.size());
                  end else if (bus.mem_req_addr !== exp_q[req_log.size()]) begin
                     errors++; $display("FAIL mem_req_addr: got %h want %h", bus.mem_req_addr, exp_q[req_log.size()]);
                  end
               end
               if (flush_word >= 0 && !flushed && req_log.size() == flush_word + 1 && bus.mem_req_valid === 1'b0) begin
                  bus.flush = 1'b1;
                  flushed   = 1'b1;
                  m_valid   = '0;
                  m_misses++;
                  for (int w = 0; w < 4; w++) exp_q.push_back(base + 32'(4 * w));
               end
            end
         end
         checks++; if (!done) begin errors++; $display("FAIL refill_timeout @%h: no hit after %0d cycles", addr, cycles); end
         checks++; if (req_log.size() != exp_q.size()) begin errors++; $display("FAIL req_count @%h: got %0d want %0d", addr, req_log.size(), exp_q.size()); end
         for (int i = 0; i < req_log.size() && i < exp_q.size(); i++) begin
            checks++; if (req_log[i] !== exp_q[i]) begin errors++; $display("FAIL req_seq[%0d]: got %h want %h", i, req_log[i], exp_q[i]); end
         end
         checks++; if (bus.cpu_rdata !== mem_word(addr)) begin errors++; $display("FAIL retry_rdata @%h: got %h want %h", addr, bus.cpu_rdata, mem_word(addr)); end
         checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL retry_stall @%h: got %b want 0", addr, bus.cpu_stall); end
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tag;
         m_hits++;
      end
      @(posedge clk); #1;
      bus.cpu_req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.cpu_req_valid = 1'b0; bus.cpu_addr = 32'd0; bus.flush = 1'b0;
      bp_left = 0; m_valid = '0; m_hits = 0; m_misses = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_stall !== 1'b0) begin
         errors++; $display("FAIL reset_cpu_out: rvalid=%b stall=%b want 0 0", bus.cpu_rvalid, bus.cpu_stall);
      end
      checks++; if (bus.mem_req_valid !== 1'b0 || bus.cpu_rdata !== 32'd0) begin
         errors++; $display("FAIL reset_mem_out: req_valid=%b rdata=%h want 0 0", bus.mem_req_valid, bus.cpu_rdata);
      end
      checks++; if (perf_hits !== '0 || perf_misses !== '0) begin
         errors++; $display("FAIL reset_perf: hits=%0d misses=%0d want 0 0", perf_hits, perf_misses);
      end
      rst = 1'b0;
      @(posedge clk); #2;
      checks++; if (bus.cpu_stall !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
         errors++; $display("FAIL idle_no_req: stall=%b req_valid=%b want 0 0", bus.cpu_stall, bus.mem_req_valid);
      end
   endtask

   task automatic test_perf(input string tag_name);
      logic [PERF_COUNTER_WIDTH-1:0] exp_h;
      logic [PERF_COUNTER_WIDTH-1:0] exp_m;
`ifdef ICACHE_PERF_EN
      exp_h = PERF_COUNTER_WIDTH'(m_hits);
      exp_m = PERF_COUNTER_WIDTH'(m_misses);
`else
      exp_h = '0;
      exp_m = '0;
`endif
      #1;
      checks++; if (perf_hits !== exp_h) begin errors++; $display("FAIL perf_hits %s: got %0d want %0d", tag_name, perf_hits, exp_h); end
      checks++; if (perf_misses !== exp_m) begin errors++; $display("FAIL perf_misses %s: got %0d want %0d", tag_name, perf_misses, exp_m); end
   endtask

   task automatic test_cold_miss();
      do_fetch(32'h0000_0040, -1);
   endtask

   task automatic test_same_line_hit();
      do_fetch(32'h0000_004C, -1);
      test_perf("same_line");
   endtask

   task automatic test_conflict();
      do_fetch(32'h0000_0240, -1);
      do_fetch(32'h0000_0040, -1);
      test_perf("conflict");
   endtask

   task automatic test_backpressure();
      bp_left = 5;
      do_fetch(32'h0000_0500, -1);
      do_fetch(32'h0000_0508, -1);
   endtask

   task automatic test_flush_idle();
      @(posedge clk); #1;
      bus.cpu_req_valid = 1'b1;
      bus.cpu_addr      = 32'h0000_0044;
      bus.flush         = 1'b1;
      #1;
      checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== mem_word(32'h44)) begin
         errors++; $display("FAIL flush_same_cycle_hit: rvalid=%b rdata=%h want 1 %h", bus.cpu_rvalid, bus.cpu_rdata, mem_word(32'h44));
      end
      m_hits++;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.cpu_req_valid = 1'b0;
      m_valid = '0;
      do_fetch(32'h0000_0504, -1);
   endtask

   task automatic test_flush_refill();
      do_fetch(32'h0000_0040, 1);
      do_fetch(32'h0000_0048, -1);
      test_perf("flush_refill");
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 50; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            @(posedge clk); #1;
            bus.flush = 1'b1;
            @(posedge clk); #1;
            bus.flush = 1'b0;
            m_valid = '0;
         end
         a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
         do_fetch(a, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      test_perf("random");
   endtask

   task automatic test_reset_mid_wait();
      int cycles;
      req_log.delete();
      @(posedge clk); #1;
      bus.cpu_req_valid = 1'b1;
      bus.cpu_addr      = 32'h0000_1040;
      cycles = 0;
      #1;
      while (!(req_log.size() >= 1 && bus.mem_req_valid === 1'b0) && cycles < 100) begin
         @(posedge clk); #2;
         cycles++;
      end
      checks++; if (cycles >= 100) begin errors++; $display("FAIL reach_wait: no accepted request in %0d cycles", cycles); end
      #1;
      rst = 1'b1;
      #1;
      checks++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== 32'd0) begin
         errors++; $display("FAIL async_reset_cpu: rvalid=%b stall=%b rdata=%h want 0 0 0", bus.cpu_rvalid, bus.cpu_stall, bus.cpu_rdata);
      end
      checks++; if (bus.mem_req_valid !== 1'b0 || perf_misses !== '0) begin
         errors++; $display("FAIL async_reset_mem: req_valid=%b misses=%0d want 0 0", bus.mem_req_valid, perf_misses);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.cpu_req_valid = 1'b0;
      m_valid = '0; m_hits = 0; m_misses = 0;
      do_fetch(32'h0000_0040, -1);
      test_perf("after_reset");
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_same_line_hit();
      test_conflict();
      test_backpressure();
      test_flush_idle();
      test_flush_refill();
      test_random();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
